// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave).
// Handshake: the master holds DMEM_READ or DMEM_WRITE high, with DMEM_ADDR,
// DMEM_WRITEDATA and DMEM_BYTE_EN stable, until a rising edge at which the
// slave presents DMEM_BUSYWAIT=0. That edge completes the transfer, and
// DMEM_READDATA is taken at that same edge.
interface mem_access_unit_if;
    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WRITEDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic [31:0] DMEM_READDATA;
    logic        DMEM_BUSYWAIT;

    modport master (
        output DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA, DMEM_BYTE_EN,
        input  DMEM_READDATA, DMEM_BUSYWAIT
    );

    modport slave (
        input  DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA, DMEM_BYTE_EN,
        output DMEM_READDATA, DMEM_BUSYWAIT
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit for an RV32I pipeline.
// It accepts a load or store from the EX/MEM register and runs it on the
// data-memory bus (IDLE -> ACCESS -> DONE). It stalls the pipeline until the
// data comes back, then extends the loaded value by funct3.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses (no bus request, one-cycle MISALIGN_FAULT pulse).
// In the default build the low address bits are ignored for those accesses.
// FSM_STATE exposes the controller state (0 IDLE, 1 ACCESS, 2 DONE).
module mem_access_unit (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_READ_EN_MEM,
    input  logic              MEM_WRITE_EN_MEM,
    input  logic [2:0]        FUNCT3_MEM,
    input  logic [31:0]       ALU_RES_MEM,
    input  logic [31:0]       STORE_DATA_MEM,
    mem_access_unit_if.master dmem,
    output logic              MEM_BUSYWAIT,
    output logic [31:0]       MEM_READ_MEM,
    output logic              MISALIGN_FAULT,
    output logic [1:0]        FSM_STATE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic        fault_q;

    logic        req;
    logic        trap;
    logic        accept;
    logic        in_access;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [3:0]  ld_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    // While reset is asserted, no new request is recognised.
    assign req       = RESET & (MEM_READ_EN_MEM | MEM_WRITE_EN_MEM);
    assign in_access = (state_q == S_ACCESS);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic misaligned;

    // Flag halfwords with an odd address and words not on a 4-byte boundary.
    // Loads and stores decode funct3 differently.
    always_comb begin
        misaligned = 1'b0;
        if (MEM_WRITE_EN_MEM) begin
            case (FUNCT3_MEM)
                3'b000:  misaligned = 1'b0;
                3'b001:  misaligned = ALU_RES_MEM[0];
                default: misaligned = |ALU_RES_MEM[1:0];
            endcase
        end else begin
            case (FUNCT3_MEM)
                3'b000, 3'b100: misaligned = 1'b0;
                3'b001, 3'b101: misaligned = ALU_RES_MEM[0];
                default:        misaligned = |ALU_RES_MEM[1:0];
            endcase
        end
    end

    assign trap = (state_q == S_IDLE) & req & misaligned;
`else
    assign trap = 1'b0;
`endif

    // A request is started only from IDLE, and only if it is not trapped.
    assign accept = (state_q == S_IDLE) & req & ~trap;

    // Next-state logic and pipeline stall.
    // The stall is raised in the same IDLE cycle that sees the request.
    always_comb begin
        state_d      = state_q;
        MEM_BUSYWAIT = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    MEM_BUSYWAIT = 1'b1;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                MEM_BUSYWAIT = 1'b1;
                if (!dmem.DMEM_BUSYWAIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Store lane enables and replicated store data, from the latched request.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = data_q;
        case (funct3_q)
            3'b000: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{data_q[7:0]}};
            end
            3'b001: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{data_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = data_q;
            end
        endcase
    end

    // Load lane enables. They mark the bytes the load will actually use.
    always_comb begin
        ld_be = 4'b1111;
        case (funct3_q)
            3'b000, 3'b100: ld_be = 4'b0001 << addr_q[1:0];
            3'b001, 3'b101: ld_be = addr_q[1] ? 4'b1100 : 4'b0011;
            default:        ld_be = 4'b1111;
        endcase
    end

    // Pick the addressed lane of the returned word and extend it by funct3.
    always_comb begin
        load_ext = dmem.DMEM_READDATA;
        ld_byte  = dmem.DMEM_READDATA[{addr_q[1:0], 3'b000} +: 8];
        ld_half  = dmem.DMEM_READDATA[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'h000000, ld_byte};
            3'b101:  load_ext = {16'h0000, ld_half};
            default: load_ext = dmem.DMEM_READDATA;
        endcase
    end

    // Bus outputs. Strobes and enables are live only in ACCESS.
    assign dmem.DMEM_READ      = in_access & ~write_q;
    assign dmem.DMEM_WRITE     = in_access & write_q;
    assign dmem.DMEM_ADDR      = {addr_q[31:2], 2'b00};
    assign dmem.DMEM_WRITEDATA = st_wdata;
    assign dmem.DMEM_BYTE_EN   = in_access ? (write_q ? st_be : ld_be) : 4'b0000;

    assign MISALIGN_FAULT = fault_q;
    assign FSM_STATE      = state_q;

    // State register, request latches, load result and fault pulse.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            data_q       <= 32'h0;
            funct3_q     <= 3'b000;
            write_q      <= 1'b0;
            fault_q      <= 1'b0;
            MEM_READ_MEM <= 32'h0;
        end else begin
            state_q <= state_d;
            fault_q <= trap;
            if (accept) begin
                addr_q   <= ALU_RES_MEM;
                data_q   <= STORE_DATA_MEM;
                funct3_q <= FUNCT3_MEM;
                // Write wins when both enables are set.
                write_q  <= MEM_WRITE_EN_MEM;
            end
            if (in_access && !dmem.DMEM_BUSYWAIT && !write_q) begin
                MEM_READ_MEM <= load_ext;
            end
            if (trap && !MEM_WRITE_EN_MEM) begin
                MEM_READ_MEM <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random bench for mem_access_unit.
// A reference model built from the load/store rules predicts stall counts,
// lane enables, replicated store data and the held load result.
module tb_mem_access_unit;

    logic        CLK;
    logic        RESET;
    logic        MEM_READ_EN_MEM;
    logic        MEM_WRITE_EN_MEM;
    logic [2:0]  FUNCT3_MEM;
    logic [31:0] ALU_RES_MEM;
    logic [31:0] STORE_DATA_MEM;
    logic        MEM_BUSYWAIT;
    logic [31:0] MEM_READ_MEM;
    logic        MISALIGN_FAULT;
    logic [1:0]  FSM_STATE;

    int          tests;
    int          failed;
    logic [31:0] model_res;
    int          st;

    mem_access_unit_if dmem_if ();

    mem_access_unit dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .MEM_READ_EN_MEM  (MEM_READ_EN_MEM),
        .MEM_WRITE_EN_MEM (MEM_WRITE_EN_MEM),
        .FUNCT3_MEM       (FUNCT3_MEM),
        .ALU_RES_MEM      (ALU_RES_MEM),
        .STORE_DATA_MEM   (STORE_DATA_MEM),
        .dmem             (dmem_if),
        .MEM_BUSYWAIT     (MEM_BUSYWAIT),
        .MEM_READ_MEM     (MEM_READ_MEM),
        .MISALIGN_FAULT   (MISALIGN_FAULT),
        .FSM_STATE        (FSM_STATE)
    );

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int load_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic int store_bytes(input logic [2:0] f3);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdat);
        int          n;
        int          off;
        logic [31:0] v;
        n = load_bytes(f3);
        if (n == 4) return rdat;
        off = (n == 1) ? int'(addr[1:0]) : (addr[1] ? 2 : 0);
        v = rdat >> (8 * off);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        int off;
        int be;
        n   = store_bytes(f3);
        off = (int'(addr[1:0]) / n) * n;
        be  = ((1 << n) - 1) << off;
        return 4'(be);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sdata);
        int          n;
        logic [31:0] w;
        n = store_bytes(f3);
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = sdata[8*(i % n) +: 8];
        end
        return w;
    endfunction

    function automatic logic model_misaligned(input logic wr, input logic [2:0] f3,
                                              input logic [31:0] addr);
        int n;
        n = wr ? store_bytes(f3) : load_bytes(f3);
        return (int'(addr[1:0]) % n) != 0;
    endfunction

    // ---------------- driver + checks for one pipeline request ----------------
    task automatic run_and_check(input string tag, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdat,
                                 input int busy, output int stalls);
        int          n_rd;
        int          n_wr;
        int          acc;
        logic [31:0] o_addr;
        logic [31:0] o_wdata;
        logic [31:0] o_res;
        logic [3:0]  o_be;
        logic        o_fault;
        logic        o_fault2;
        logic        active;
        logic        trap;
        logic        exp_access;
        logic        timed_out;

        active = rd | wr;
        trap   = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        trap = active && model_misaligned(wr, f3, addr);
`endif
        exp_access = active && !trap;

        @(posedge CLK); #1;
        MEM_READ_EN_MEM        = rd;
        MEM_WRITE_EN_MEM       = wr;
        FUNCT3_MEM             = f3;
        ALU_RES_MEM            = addr;
        STORE_DATA_MEM         = sdata;
        dmem_if.DMEM_READDATA  = rdat;
        dmem_if.DMEM_BUSYWAIT  = 1'b1;

        stalls    = 0;
        n_rd      = 0;
        n_wr      = 0;
        acc       = 0;
        o_addr    = 32'h0;
        o_wdata   = 32'h0;
        o_be      = 4'h0;
        o_res     = 32'h0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge CLK);
            if (dmem_if.DMEM_READ || dmem_if.DMEM_WRITE) begin
                acc++;
                n_rd   += int'(dmem_if.DMEM_READ);
                n_wr   += int'(dmem_if.DMEM_WRITE);
                o_addr  = dmem_if.DMEM_ADDR;
                o_wdata = dmem_if.DMEM_WRITEDATA;
                o_be    = dmem_if.DMEM_BYTE_EN;
            end
            // memory stays busy for the first 'busy' strobe cycles
            dmem_if.DMEM_BUSYWAIT = (acc <= busy);
            if (MEM_BUSYWAIT) begin
                stalls++;
            end else begin
                o_res     = MEM_READ_MEM;
                timed_out = 1'b0;
                break;
            end
        end

        @(posedge CLK); #1;
        MEM_READ_EN_MEM       = 1'b0;
        MEM_WRITE_EN_MEM      = 1'b0;
        dmem_if.DMEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        o_fault = MISALIGN_FAULT;
        @(negedge CLK);
        o_fault2 = MISALIGN_FAULT;

        if (exp_access && !wr) model_res = model_load(f3, addr, rdat);
        if (trap && !wr)       model_res = 32'h0;

        check($sformatf("%s/timeout", tag), 32'(timed_out), 32'h0);
        check($sformatf("%s/stalls", tag), 32'(stalls), exp_access ? 32'(busy + 2) : 32'h0);
        check($sformatf("%s/n_write", tag), 32'(n_wr), (exp_access && wr) ? 32'(busy + 1) : 32'h0);
        check($sformatf("%s/n_read", tag), 32'(n_rd), (exp_access && !wr) ? 32'(busy + 1) : 32'h0);
        if (exp_access) begin
            check($sformatf("%s/addr", tag), o_addr, {addr[31:2], 2'b00});
        end
        if (exp_access && wr) begin
            check($sformatf("%s/byte_en", tag), {28'h0, o_be}, {28'h0, model_be(f3, addr)});
            check($sformatf("%s/wdata", tag), o_wdata, model_wdata(f3, sdata));
        end
        check($sformatf("%s/result", tag), o_res, model_res);
        check($sformatf("%s/fault", tag), {31'h0, o_fault}, {31'h0, trap});
        check($sformatf("%s/fault_end", tag), {31'h0, o_fault2}, 32'h0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        tests                 = 0;
        failed                = 0;
        model_res             = 32'h0;
        RESET                 = 1'b0;
        MEM_READ_EN_MEM       = 1'b0;
        MEM_WRITE_EN_MEM      = 1'b0;
        FUNCT3_MEM            = 3'b000;
        ALU_RES_MEM           = 32'h0;
        STORE_DATA_MEM        = 32'h0;
        dmem_if.DMEM_READDATA = 32'h0;
        dmem_if.DMEM_BUSYWAIT = 1'b1;

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst/read", {31'h0, dmem_if.DMEM_READ}, 32'h0);
        check("rst/write", {31'h0, dmem_if.DMEM_WRITE}, 32'h0);
        check("rst/byte_en", {28'h0, dmem_if.DMEM_BYTE_EN}, 32'h0);
        check("rst/result", MEM_READ_MEM, 32'h0);
        check("rst/fault", {31'h0, MISALIGN_FAULT}, 32'h0);
        check("rst/busywait", {31'h0, MEM_BUSYWAIT}, 32'h0);
        check("rst/state", {30'h0, FSM_STATE}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b1;

        // LB from byte 3, memory busy 3 cycles
        run_and_check("lb", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3, st);
        check("lb/stall5", 32'(st), 32'd5);
        check("lb/value", MEM_READ_MEM, 32'hFFFF_FF80);

        // LHU from the upper half, zero-wait memory
        run_and_check("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, st);
        check("lhu/stall2", 32'(st), 32'd2);
        check("lhu/value", MEM_READ_MEM, 32'h0000_BEEF);

        // SB to byte 1: result register must keep the LHU value
        run_and_check("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 1, st);
        check("sb/held", MEM_READ_MEM, 32'h0000_BEEF);

        // read and write together: write wins
        run_and_check("rw_sw", 1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 0, st);

        // SH to upper half, LH negative
        run_and_check("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h0000_C3D4, 32'h0, 2, st);
        run_and_check("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'h0, 32'h0000_8001, 0, st);

        // misaligned LW: trapped or word-aligned depending on build
        run_and_check("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0, st);

        // reset in the middle of an access with memory still busy
        @(posedge CLK); #1;
        MEM_READ_EN_MEM       = 1'b1;
        FUNCT3_MEM            = 3'b010;
        ALU_RES_MEM           = 32'h0000_0040;
        dmem_if.DMEM_BUSYWAIT = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_mid/in_access", {31'h0, dmem_if.DMEM_READ}, 32'h1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_mid/read", {31'h0, dmem_if.DMEM_READ}, 32'h0);
        check("rst_mid/write", {31'h0, dmem_if.DMEM_WRITE}, 32'h0);
        check("rst_mid/busywait", {31'h0, MEM_BUSYWAIT}, 32'h0);
        check("rst_mid/state", {30'h0, FSM_STATE}, 32'h0);
        check("rst_mid/result", MEM_READ_MEM, 32'h0);
        model_res = 32'h0;
        @(posedge CLK); #1;
        RESET            = 1'b1;
        MEM_READ_EN_MEM  = 1'b0;
        MEM_WRITE_EN_MEM = 1'b0;

        // random traffic
        for (int i = 0; i < 40; i++) begin
            run_and_check($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 3)), st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL expose: CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL expose: RESET  in  1  synchronous, active-low reset (0 = reset, sampled on CLK rising edge).
REQ-003 SHALL expose: MEM_READ_EN_MEM  in  1  load request from EX/MEM register.
REQ-004 SHALL expose: MEM_WRITE_EN_MEM  in  1  store request from EX/MEM register.
REQ-005 SHALL expose: FUNCT3_MEM  in  3  access size/sign (RV32I load/store funct3).
REQ-006 SHALL expose: ALU_RES_MEM  in  32  byte address.
REQ-007 SHALL expose: STORE_DATA_MEM  in  32  rs2 value for stores.
REQ-008 SHALL expose: DMEM_READ / DMEM_WRITE  out  1 each  data-memory request strobes.
REQ-009 SHALL expose: DMEM_ADDR  out  32  word address, bits [1:0] always 0.
REQ-010 SHALL expose: DMEM_WRITEDATA  out  32  lane-replicated store data; DMEM_BYTE_EN  out  4  lane enables.
REQ-011 SHALL expose: DMEM_READDATA  in  32; DMEM_BUSYWAIT  in  1  memory not yet done.
REQ-012 SHALL expose: MEM_BUSYWAIT  out  1  pipeline stall (feeds MEM/WB and earlier stages).
REQ-013 SHALL expose: MEM_READ_MEM  out  32  extended load result for MEM/WB; MISALIGN_FAULT  out  1.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-015 IDLE with read or write enable asserted: MEM_BUSYWAIT=1 combinationally in that cycle; latch address, data, funct3, direction; go ACCESS.
REQ-016 Write enable SHALL take priority when both read and write are asserted; the read is ignored.
REQ-017 ACCESS: DMEM_READ or DMEM_WRITE held at 1 with stable ADDR/WRITEDATA/BYTE_EN, MEM_BUSYWAIT=1; on edge with DMEM_BUSYWAIT=0 go DONE, drop strobes, register extended load data.
REQ-018 DONE: MEM_BUSYWAIT=0 for exactly one cycle; then IDLE unconditionally (a new access is seen there).
REQ-019 Minimum latency: 2 stall cycles; result valid on MEM_READ_MEM during DONE and held until the next load completes.
REQ-020 Load extension by funct3: 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext; other codes SHALL behave as LW.
REQ-021 Byte lane = addr[1:0]; halfword lane = addr[1].
REQ-022 Store enables: SB 4'b0001<<addr[1:0], data byte replicated x4; SH 4'b0011 or 4'b1100 by addr[1], half replicated x2; SW (and other codes) 4'b1111.
REQ-023 No request in IDLE: MEM_BUSYWAIT=0, strobes 0, MEM_READ_MEM unchanged.
REQ-024 Stores SHALL NOT modify MEM_READ_MEM.

Reset
REQ-025 RESET=0 at an edge: state IDLE; DMEM_READ, DMEM_WRITE, DMEM_BYTE_EN, MEM_READ_MEM, MISALIGN_FAULT, latched regs = 0.
REQ-026 Reset mid-ACCESS SHALL abandon the access; strobes low from the following cycle regardless of DMEM_BUSYWAIT.
REQ-027 Reset SHALL take priority over every other condition.

Configuration
REQ-028 Macro MEM_ACCESS_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no DMEM request, keep MEM_BUSYWAIT=0, pulse MISALIGN_FAULT for one cycle, set MEM_READ_MEM=0.
REQ-029 Macro undefined: MISALIGN_FAULT tied 0; misaligned halfwords ignore addr[0], misaligned words ignore addr[1:0]; access proceeds normally.

Verification
REQ-030 LB at 0x0000_1003, DMEM_READDATA=0x80FF_0000, memory busy 3 cycles -> MEM_BUSYWAIT high 5 cycles, DMEM_ADDR=0x0000_1000, MEM_READ_MEM=0xFFFF_FF80.
REQ-031 LHU at 0x0000_2002, DMEM_READDATA=0xBEEF_1234, zero-wait memory -> 2 stall cycles, MEM_READ_MEM=0x0000_BEEF.
REQ-032 SB 0x0000_00A5 at 0x0000_0101 -> DMEM_BYTE_EN=4'b0010, DMEM_WRITEDATA=0xA5A5_A5A5, MEM_READ_MEM unchanged.
REQ-033 Read and write both asserted, SW at 0x10 -> only DMEM_WRITE=1, BYTE_EN=4'b1111.
REQ-034 RESET=0 during ACCESS with DMEM_BUSYWAIT=1 -> next cycle strobes 0, MEM_BUSYWAIT=0, state IDLE.
REQ-035 With MEM_ACCESS_MISALIGN_TRAP_EN: LW at 0x0000_0006 -> no DMEM strobe, MISALIGN_FAULT one-cycle pulse; without macro -> DMEM_ADDR=0x0000_0004, normal load.
